// File: rtl/pio_arb_pkg.sv
// Shared types and constants for the PIO read arbiter.
// Optional statistics (grant counters) are enabled with PIO_ARB_STATS_EN.
package pio_arb_pkg;

    // Arbiter sequencing states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } arb_state_t;

    // Per-requester grant counter width and saturation value
    localparam int               STAT_W   = 16;
    localparam logic [STAT_W-1:0] STAT_MAX = 16'hFFFF;

    // Width of the read-latency down-counter; it must hold READ_LATENCY itself
    function automatic int lat_cnt_w(input int read_latency);
        return $clog2(read_latency + 1);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin priority encoder: returns the first requester at
// or above ptr, wrapping modulo N. Usable by any shared-slave arbiter.
module rr_pick #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic             any,
    output logic [IDX_W-1:0] idx
);

    // cand[k] is the requester index k positions after ptr (mod N)
    logic [IDX_W-1:0] cand [N];
    logic [N-1:0]     hit;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_cand
            logic [IDX_W:0] sum;
            assign sum       = {1'b0, ptr} + (IDX_W+1)'(gi);
            assign cand[gi]  = (sum >= (IDX_W+1)'(N)) ? IDX_W'(sum - (IDX_W+1)'(N))
                                                      : IDX_W'(sum);
            assign hit[gi]   = req[cand[gi]];
        end
    endgenerate

    // Nearest hit to ptr wins: scan from the far end so the closest overwrites last
    always_comb begin
        any = |hit;
        idx = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (hit[k]) begin
                idx = cand[k];
            end
        end
    end

endmodule

// File: rtl/pio_read_arbiter.sv
// Round-robin arbiter sharing one read-only Avalon-MM PIO slave among
// NUM_REQ requesters. Each read: arbitrate (IDLE), present address with
// m_read for one cycle (ISSUE), wait READ_LATENCY cycles (WAIT), then return
// the captured data with a one-cycle one-hot readdatavalid.
// Optional macro PIO_ARB_STATS_EN adds stats_clear / grant_count counters.
module pio_read_arbiter
    import pio_arb_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int ADDR_W       = 2,
    parameter int DATA_W       = 32,
    parameter int READ_LATENCY = 1
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_REQ-1:0]        req_read,
    input  logic [NUM_REQ*ADDR_W-1:0] req_address,
    output logic [NUM_REQ-1:0]        req_waitrequest,
    output logic [DATA_W-1:0]         req_readdata,
    output logic [NUM_REQ-1:0]        req_readdatavalid,
    output logic [ADDR_W-1:0]         m_address,
    output logic                      m_read,
    input  logic [DATA_W-1:0]         m_readdata
`ifdef PIO_ARB_STATS_EN
    ,
    input  logic                      stats_clear,
    output logic [NUM_REQ*STAT_W-1:0] grant_count
`endif
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = lat_cnt_w(READ_LATENCY);

    arb_state_t          state_reg,  state_next;
    logic [IDX_W-1:0]    rr_ptr_reg, rr_ptr_next;
    logic [IDX_W-1:0]    grant_reg,  grant_next;
    logic [CNT_W-1:0]    cnt_reg,    cnt_next;
    logic [ADDR_W-1:0]   addr_reg,   addr_next;
    logic [DATA_W-1:0]   rdata_reg;
    logic [NUM_REQ-1:0]  valid_reg,  valid_next;
    logic                capture;
    logic                m_read_c;
    logic [NUM_REQ-1:0]  accept;

    logic                pick_any;
    logic [IDX_W-1:0]    pick_idx;

    rr_pick #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req (req_read),
        .ptr (rr_ptr_reg),
        .any (pick_any),
        .idx (pick_idx)
    );

    // Next-state and per-state outputs of the read sequencer
    always_comb begin
        state_next  = state_reg;
        rr_ptr_next = rr_ptr_reg;
        grant_next  = grant_reg;
        cnt_next    = cnt_reg;
        addr_next   = addr_reg;
        valid_next  = '0;
        capture     = 1'b0;
        m_read_c    = 1'b0;
        accept      = '0;
        case (state_reg)
            IDLE: begin
                if (pick_any) begin
                    grant_next = pick_idx;
                    addr_next  = req_address[pick_idx*ADDR_W +: ADDR_W];
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                m_read_c         = 1'b1;
                accept[grant_reg] = 1'b1;
                cnt_next         = CNT_W'(READ_LATENCY);
                rr_ptr_next      = (grant_reg == IDX_W'(NUM_REQ - 1)) ? '0
                                                                      : grant_reg + 1'b1;
                state_next       = WAIT;
            end
            WAIT: begin
                cnt_next = cnt_reg - 1'b1;
                if (cnt_reg == CNT_W'(1)) begin
                    capture              = 1'b1;
                    valid_next[grant_reg] = 1'b1;
                    state_next           = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Sequencer registers; an aborted read never produces a valid pulse
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg  <= IDLE;
            rr_ptr_reg <= '0;
            grant_reg  <= '0;
            cnt_reg    <= '0;
            addr_reg   <= '0;
            rdata_reg  <= '0;
            valid_reg  <= '0;
        end else begin
            state_reg  <= state_next;
            rr_ptr_reg <= rr_ptr_next;
            grant_reg  <= grant_next;
            cnt_reg    <= cnt_next;
            addr_reg   <= addr_next;
            valid_reg  <= valid_next;
            if (capture) begin
                rdata_reg <= m_readdata;
            end
        end
    end

    assign m_address         = addr_reg;
    assign m_read            = m_read_c;
    assign req_waitrequest   = ~accept;
    assign req_readdata      = rdata_reg;
    assign req_readdatavalid = valid_reg;

`ifdef PIO_ARB_STATS_EN
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_stat
            logic [STAT_W-1:0] count_reg;

            // Saturating acceptance counter; clear wins over a same-cycle increment
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    count_reg <= '0;
                end else if (stats_clear) begin
                    count_reg <= '0;
                end else if (accept[gi] && (count_reg != STAT_MAX)) begin
                    count_reg <= count_reg + 1'b1;
                end
            end

            assign grant_count[gi*STAT_W +: STAT_W] = count_reg;
        end
    endgenerate
`endif

endmodule

// File: tb/tb_pio_read_arbiter.sv
// Self-checking bench for pio_read_arbiter: one instance with READ_LATENCY=1
// and one with READ_LATENCY=3, selected by sel. Outputs are sampled and
// inputs driven on the falling clock edge.
module tb_pio_read_arbiter;

    localparam int N  = 4;
    localparam int AW = 2;
    localparam int DW = 32;
    localparam logic [31:0] JUNK = 32'h5A5A_A5A5;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic              sel = 1'b0;
    logic [N-1:0]      req_read = '0;
    logic [N*AW-1:0]   req_address = '0;

    logic [N-1:0]  rr1, rr3, wait1, wait3, valid1, valid3;
    logic [DW-1:0] rdata1, rdata3, m_readdata1, m_readdata3;
    logic [AW-1:0] m_address1, m_address3;
    logic          m_read1, m_read3;

    logic [N-1:0]  obs_wait, obs_valid;
    logic [DW-1:0] obs_rdata;
    logic [AW-1:0] obs_maddr;
    logic          obs_mread;

`ifdef PIO_ARB_STATS_EN
    logic            stats_clear = 1'b0;
    logic [N*16-1:0] grant_count1, grant_count3;
`endif

    int total = 0;
    int bad   = 0;

    assign rr1 = sel ? '0 : req_read;
    assign rr3 = sel ? req_read : '0;
    assign obs_wait  = sel ? wait3 : wait1;
    assign obs_valid = sel ? valid3 : valid1;
    assign obs_rdata = sel ? rdata3 : rdata1;
    assign obs_maddr = sel ? m_address3 : m_address1;
    assign obs_mread = sel ? m_read3 : m_read1;

    // Slave models: registered PIO data, garbled unless the slot carries a read
    logic [31:0] mem [4];
    logic [31:0] slv1_q;
    logic [31:0] slv3_q [3];
    always @(posedge clk) slv1_q <= mem[m_address1] ^ (m_read1 ? 32'h0 : JUNK);
    always @(posedge clk) begin
        slv3_q[0] <= mem[m_address3] ^ (m_read3 ? 32'h0 : JUNK);
        slv3_q[1] <= slv3_q[0];
        slv3_q[2] <= slv3_q[1];
    end
    assign m_readdata1 = slv1_q;
    assign m_readdata3 = slv3_q[2];

    pio_read_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .req_read(rr1), .req_address(req_address),
        .req_waitrequest(wait1), .req_readdata(rdata1), .req_readdatavalid(valid1),
        .m_address(m_address1), .m_read(m_read1), .m_readdata(m_readdata1)
`ifdef PIO_ARB_STATS_EN
        , .stats_clear(stats_clear), .grant_count(grant_count1)
`endif
    );

    pio_read_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(3)) dut3 (
        .clk(clk), .reset_n(reset_n), .req_read(rr3), .req_address(req_address),
        .req_waitrequest(wait3), .req_readdata(rdata3), .req_readdatavalid(valid3),
        .m_address(m_address3), .m_read(m_read3), .m_readdata(m_readdata3)
`ifdef PIO_ARB_STATS_EN
        , .stats_clear(stats_clear), .grant_count(grant_count3)
`endif
    );

    task automatic apply_reset();
        req_read = '0;
        reset_n  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        sel = 1'b0;
        req_read = '0;
        reset_n = 1'b0;
        @(negedge clk);
        total++; if (obs_wait !== 4'hF) begin bad++; $display("FAIL reset_wait: got %b want 1111", obs_wait); end
        total++; if (obs_valid !== 4'h0) begin bad++; $display("FAIL reset_valid: got %b want 0000", obs_valid); end
        total++; if (obs_rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata: got %h want 0", obs_rdata); end
        total++; if (obs_mread !== 1'b0) begin bad++; $display("FAIL reset_mread: got %b want 0", obs_mread); end
        total++; if (obs_maddr !== 2'd0) begin bad++; $display("FAIL reset_maddr: got %0d want 0", obs_maddr); end
        reset_n = 1'b1;
        $display("reset checked");
    endtask

    task automatic test_single();
        sel = 1'b0;
        apply_reset();
        mem[0] = 32'hDEADBEEF;
        req_address[4 +: 2] = 2'd0;
        req_read = 4'b0100;
        @(negedge clk); // t1
        total++; if (obs_wait !== 4'b1011) begin bad++; $display("FAIL single_accept: got %b want 1011", obs_wait); end
        total++; if (obs_mread !== 1'b1) begin bad++; $display("FAIL single_mread: got %b want 1", obs_mread); end
        total++; if (obs_maddr !== 2'd0) begin bad++; $display("FAIL single_maddr: got %0d want 0", obs_maddr); end
        req_read = '0;
        @(negedge clk); // t2
        total++; if (obs_valid !== 4'b0000) begin bad++; $display("FAIL single_early_valid: got %b want 0000", obs_valid); end
        @(negedge clk); // t3
        total++; if (obs_valid !== 4'b0100) begin bad++; $display("FAIL single_valid: got %b want 0100", obs_valid); end
        total++; if (obs_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL single_rdata: got %h want deadbeef", obs_rdata); end
        $display("txn single req=2 data=%h", obs_rdata);
        @(negedge clk); // t4
        total++; if (obs_valid !== 4'b0000) begin bad++; $display("FAIL single_valid_once: got %b want 0000", obs_valid); end
        total++; if (obs_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL single_rdata_hold: got %h want deadbeef", obs_rdata); end
    endtask

    task automatic test_contention();
        int order[$];
        int exp_order[5];
        logic [3:0] exp_w, exp_v;
        exp_order = '{0, 1, 2, 3, 0};
        sel = 1'b0;
        apply_reset();
        req_address = {2'd3, 2'd2, 2'd1, 2'd0};
        req_read = 4'hF;
        for (int c = 0; c < 16; c++) begin
            exp_w = 4'hF;
            exp_v = 4'h0;
            if (c % 3 == 1) exp_w[((c - 1) / 3) % 4] = 1'b0;
            if (c >= 3 && c % 3 == 0) exp_v[((c - 3) / 3) % 4] = 1'b1;
            total++; if (obs_wait !== exp_w) begin bad++; $display("FAIL contention_wait c=%0d: got %b want %b", c, obs_wait, exp_w); end
            total++; if (obs_valid !== exp_v) begin bad++; $display("FAIL contention_valid c=%0d: got %b want %b", c, obs_valid, exp_v); end
            for (int i = 0; i < 4; i++) if (!obs_wait[i]) order.push_back(i);
            if (obs_valid != 0) $display("txn contention valid=%b data=%h", obs_valid, obs_rdata);
            @(negedge clk);
        end
        total++; if (order.size() != 5) begin bad++; $display("FAIL contention_count: got %0d want 5", order.size()); end
        for (int k = 0; k < 5; k++) begin
            if (k < order.size()) begin
                total++; if (order[k] != exp_order[k]) begin bad++; $display("FAIL contention_order k=%0d: got %0d want %0d", k, order[k], exp_order[k]); end
            end
        end
    endtask

    task automatic test_wrap();
        logic [3:0] t_set [11];
        logic [3:0] t_w   [11];
        logic [3:0] t_v   [11];
        t_set = '{4'b0100, 4'b0000, 4'b0000, 4'b1010, 4'b0010, 4'b0010,
                  4'b0010, 4'b0000, 4'b0000, 4'b0101, 4'b0001};
        t_w   = '{4'hF, 4'b1011, 4'hF, 4'hF, 4'b0111, 4'hF,
                  4'hF, 4'b1101, 4'hF, 4'hF, 4'b1011};
        t_v   = '{4'h0, 4'h0, 4'h0, 4'b0100, 4'h0, 4'h0,
                  4'b1000, 4'h0, 4'h0, 4'b0010, 4'h0};
        sel = 1'b0;
        apply_reset();
        req_address = {2'd3, 2'd2, 2'd1, 2'd0};
        for (int c = 0; c < 11; c++) begin
            total++; if (obs_wait !== t_w[c]) begin bad++; $display("FAIL wrap_wait c=%0d: got %b want %b", c, obs_wait, t_w[c]); end
            total++; if (obs_valid !== t_v[c]) begin bad++; $display("FAIL wrap_valid c=%0d: got %b want %b", c, obs_valid, t_v[c]); end
            if (obs_valid != 0) $display("txn wrap valid=%b data=%h", obs_valid, obs_rdata);
            req_read = t_set[c];
            @(negedge clk);
        end
    endtask

    task automatic test_latency3();
        sel = 1'b1;
        apply_reset();
        for (int i = 0; i < 4; i++) mem[i] = $urandom;
        req_address = {2'd0, 2'd0, 2'd2, 2'd0};
        req_read = 4'b0010;
        @(negedge clk); // t1
        total++; if (obs_wait !== 4'b1101) begin bad++; $display("FAIL lat3_accept: got %b want 1101", obs_wait); end
        req_read = 4'b1000; // another master arrives with a different address
        for (int c = 2; c <= 4; c++) begin
            @(negedge clk);
            total++; if (obs_valid !== 4'h0) begin bad++; $display("FAIL lat3_early_valid c=%0d: got %b want 0000", c, obs_valid); end
            total++; if (obs_maddr !== 2'd2) begin bad++; $display("FAIL lat3_maddr_hold c=%0d: got %0d want 2", c, obs_maddr); end
        end
        @(negedge clk); // t5 = accept + 4
        total++; if (obs_valid !== 4'b0010) begin bad++; $display("FAIL lat3_valid: got %b want 0010", obs_valid); end
        total++; if (obs_rdata !== mem[2]) begin bad++; $display("FAIL lat3_rdata: got %h want %h", obs_rdata, mem[2]); end
        $display("txn lat3 req=1 data=%h", obs_rdata);
        @(negedge clk); // t6: requester 3 accepted
        total++; if (obs_wait !== 4'b0111) begin bad++; $display("FAIL lat3_second_accept: got %b want 0111", obs_wait); end
        req_read = '0;
    endtask

    task automatic test_reset_mid();
        sel = 1'b1;
        req_read = '0;
        repeat (8) @(negedge clk); // let the previous read finish, leaving data held
        req_address[4 +: 2] = 2'd1;
        req_read = 4'b0100;
        @(negedge clk);
        total++; if (obs_wait !== 4'b1011) begin bad++; $display("FAIL rstmid_accept: got %b want 1011", obs_wait); end
        req_read = '0;
        @(negedge clk); // in WAIT
        reset_n = 1'b0;
        #1;
        total++; if (obs_wait !== 4'hF) begin bad++; $display("FAIL rstmid_wait: got %b want 1111", obs_wait); end
        total++; if (obs_valid !== 4'h0) begin bad++; $display("FAIL rstmid_valid: got %b want 0000", obs_valid); end
        total++; if (obs_rdata !== 32'h0) begin bad++; $display("FAIL rstmid_rdata: got %h want 0", obs_rdata); end
        total++; if (obs_maddr !== 2'd0) begin bad++; $display("FAIL rstmid_maddr: got %0d want 0", obs_maddr); end
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            total++; if (obs_valid !== 4'h0) begin bad++; $display("FAIL rstmid_stray_valid c=%0d: got %b want 0000", c, obs_valid); end
            @(negedge clk);
        end
        req_read = 4'hF;
        @(negedge clk);
        total++; if (obs_wait !== 4'b1110) begin bad++; $display("FAIL rstmid_first_grant: got %b want 1110", obs_wait); end
        $display("txn reset_mid next_grant_wait=%b", obs_wait);
        req_read = '0;
    endtask

    // Randomised traffic against a transaction-level model: each free slot
    // arbitrates the pending set, then occupies the slave for lat+2 cycles.
    task automatic test_random(input bit use3, input int cycles, input int pct);
        int lat, ptr, idle_c, acc_c, val_c, acc_i, val_i, w, j;
        logic [31:0] exp_d;
        logic [1:0]  exp_ma;
        logic [3:0]  exp_w, exp_v;
        sel = use3;
        lat = use3 ? 3 : 1;
        apply_reset();
        for (int i = 0; i < 4; i++) mem[i] = $urandom;
        ptr = 0; idle_c = 0; acc_c = -1; val_c = -1; acc_i = 0; val_i = 0;
        exp_d = '0; exp_ma = '0;
        for (int c = 0; c < cycles; c++) begin
            exp_w = 4'hF;
            exp_v = 4'h0;
            if (c == acc_c) exp_w[acc_i] = 1'b0;
            if (c == val_c) exp_v[val_i] = 1'b1;
            total++; if (obs_wait !== exp_w) begin bad++; $display("FAIL rand_wait L%0d c=%0d: got %b want %b", lat, c, obs_wait, exp_w); end
            total++; if (obs_mread !== (c == acc_c)) begin bad++; $display("FAIL rand_mread L%0d c=%0d: got %b want %b", lat, c, obs_mread, (c == acc_c)); end
            total++; if (obs_valid !== exp_v) begin bad++; $display("FAIL rand_valid L%0d c=%0d: got %b want %b", lat, c, obs_valid, exp_v); end
            total++; if (obs_maddr !== exp_ma) begin bad++; $display("FAIL rand_maddr L%0d c=%0d: got %0d want %0d", lat, c, obs_maddr, exp_ma); end
            if (c == val_c) begin
                total++; if (obs_rdata !== exp_d) begin bad++; $display("FAIL rand_rdata L%0d c=%0d: got %h want %h", lat, c, obs_rdata, exp_d); end
                $display("txn rand L%0d req=%0d data=%h", lat, val_i, obs_rdata);
            end
            // requesters: drop on acceptance, otherwise hold; idle ones may start a read
            for (int i = 0; i < 4; i++) begin
                if (req_read[i] && !obs_wait[i]) req_read[i] = 1'b0;
                if (!req_read[i] && ($urandom_range(99) < pct)) begin
                    req_read[i] = 1'b1;
                    req_address[i*2 +: 2] = 2'($urandom_range(3));
                end
            end
            if (c == idle_c) begin
                if (req_read != 0) begin
                    w = -1;
                    for (int k = 0; k < 4; k++) begin
                        j = (ptr + k) % 4;
                        if (w < 0 && req_read[j]) w = j;
                    end
                    acc_c  = c + 1;
                    acc_i  = w;
                    val_c  = c + lat + 2;
                    val_i  = w;
                    exp_ma = req_address[w*2 +: 2];
                    exp_d  = mem[exp_ma];
                    ptr    = (w + 1) % 4;
                    idle_c = c + lat + 2;
                end else begin
                    idle_c = c + 1;
                end
            end
            @(negedge clk);
        end
        req_read = '0;
    endtask

`ifdef PIO_ARB_STATS_EN
    task automatic test_stats();
        bit hit;
        sel = 1'b0;
        stats_clear = 1'b0;
        apply_reset();
        total++; if (grant_count1 !== '0) begin bad++; $display("FAIL stats_reset: got %h want 0", grant_count1); end
        req_read = 4'b0010;
        repeat (40) @(negedge clk); // acceptances at cycles 1,4,...,37
        total++; if (grant_count1[16 +: 16] !== 16'd13) begin bad++; $display("FAIL stats_count: got %0d want 13", grant_count1[16 +: 16]); end
        total++; if (grant_count1[0 +: 16] !== 16'd0) begin bad++; $display("FAIL stats_other: got %0d want 0", grant_count1[0 +: 16]); end
        hit = 1'b0;
        for (int c = 0; c < 5 && !hit; c++) begin
            if (!obs_wait[1]) hit = 1'b1;
            else @(negedge clk);
        end
        total++; if (!hit) begin bad++; $display("FAIL stats_accept_timeout: got none want acceptance"); end
        stats_clear = 1'b1;
        @(negedge clk);
        stats_clear = 1'b0;
        total++; if (grant_count1[16 +: 16] !== 16'd0) begin bad++; $display("FAIL stats_clear_priority: got %0d want 0", grant_count1[16 +: 16]); end
        $display("txn stats count1=%0d", grant_count1[16 +: 16]);
        req_read = '0;
    endtask
`endif

    initial begin
        for (int i = 0; i < 4; i++) mem[i] = 32'h1000_0000 + 32'(i);
        test_reset();
        test_single();
        test_contention();
        test_wrap();
        test_latency3();
        test_reset_mid();
        test_random(1'b0, 300, 40);
        test_random(1'b1, 300, 30);
`ifdef PIO_ARB_STATS_EN
        test_stats();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
